wavegen_nco: RTL and testbench

Parametrised numerically-controlled waveform generator: a phase accumulator with a programmable frequency word drives sawtooth, inverse-sawtooth, square (programmable duty), triangle and external-ROM waveforms of configurable sample width. Configuration is double-buffered and takes effect only at a phase wrap, so frequency, duty and wave changes never produce a mid-period glitch. It feeds the DAC/output path in place of the fixed-rate, fixed-width generators.

---
 rtl/wavegen_nco_if.sv | 45 ++++
 rtl/wavegen_nco.sv | 160 ++++++++++++++++
 tb/tb_wavegen_nco.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wavegen_nco_if.sv
// wavegen_nco_if: bus bundle for the NCO waveform generator.
//   Configuration : freqWord, duty, waveSelector, cfgLoad (in), cfgBusy (out)
//   External ROM  : romAddr (out), romIn (in, asynchronous read)
//   Sample output : dataOut, dataValid, wrapPulse (out)
//   amplitude     : output scale, present only when WAVEGEN_AMP_EN is defined
// slave modport is the generator side, master modport is the driving side.
interface wavegen_nco_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned ROM_AW  = 8
);
    logic [PHASE_W-1:0] freqWord;
    logic [DATA_W-1:0]  duty;
    logic [2:0]         waveSelector;
    logic               cfgLoad;
    logic               cfgBusy;
    logic [ROM_AW-1:0]  romAddr;
    logic [DATA_W-1:0]  romIn;
`ifdef WAVEGEN_AMP_EN
    logic [DATA_W-1:0]  amplitude;
`endif
    logic [DATA_W-1:0]  dataOut;
    logic               dataValid;
    logic               wrapPulse;

`ifdef WAVEGEN_AMP_EN
    modport slave (
        input  freqWord, duty, waveSelector, cfgLoad, romIn, amplitude,
        output cfgBusy, romAddr, dataOut, dataValid, wrapPulse
    );
    modport master (
        output freqWord, duty, waveSelector, cfgLoad, romIn, amplitude,
        input  cfgBusy, romAddr, dataOut, dataValid, wrapPulse
    );
`else
    modport slave (
        input  freqWord, duty, waveSelector, cfgLoad, romIn,
        output cfgBusy, romAddr, dataOut, dataValid, wrapPulse
    );
    modport master (
        output freqWord, duty, waveSelector, cfgLoad, romIn,
        input  cfgBusy, romAddr, dataOut, dataValid, wrapPulse
    );
`endif
endinterface

// File: rtl/wavegen_nco.sv
// wavegen_nco: numerically-controlled waveform generator.
// A phase accumulator advanced by a frequency word drives sawtooth, square
// (programmable duty), triangle, inverse sawtooth and external-ROM waveforms.
// Configuration is double-buffered: cfgLoad captures into pending registers,
// which are copied to the active set only at a phase wrap (or immediately when
// the active frequency is zero), so output periods are never cut short.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - wavegen_nco_if.slave (config, ROM, sample output, optional amplitude)
// Build option: WAVEGEN_AMP_EN adds an amplitude scaling stage
//   (dataOut = sample * (amplitude+1) >> DATA_W) and one cycle of latency.
module wavegen_nco #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned ROM_AW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    wavegen_nco_if.slave  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } cfg_state_e;

    localparam logic [DATA_W-1:0] DUTY_RST = {1'b1, {(DATA_W-1){1'b0}}};

    logic [PHASE_W-1:0] phase_q,     phase_d;
    logic [PHASE_W-1:0] act_freq_q,  act_freq_d;
    logic [DATA_W-1:0]  act_duty_q,  act_duty_d;
    logic [2:0]         act_sel_q,   act_sel_d;
    logic [PHASE_W-1:0] pend_freq_q, pend_freq_d;
    logic [DATA_W-1:0]  pend_duty_q, pend_duty_d;
    logic [2:0]         pend_sel_q,  pend_sel_d;
    cfg_state_e         state_q,     state_d;
    logic [DATA_W-1:0]  data_q,      data_d;
    logic               valid_q,     valid_d;
    logic               wrap_q,      wrap_d;
`ifdef WAVEGEN_AMP_EN
    logic [DATA_W-1:0]  stage_q,     stage_d;
    logic               stage_vld_q, stage_vld_d;
    logic [DATA_W:0]    amp_p1;
    logic [2*DATA_W:0]  product;
`endif

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic [DATA_W-1:0]  p;
    logic [DATA_W-1:0]  tri_up;
    logic [DATA_W-1:0]  sample;

    // Waveform sample from the current phase register and active config.
    always_comb begin
        p      = phase_q[PHASE_W-1 -: DATA_W];
        tri_up = {p[DATA_W-2:0], 1'b0};
        sample = '0;
        unique case (act_sel_q)
            3'b000:  sample = p;
            3'b001:  sample = (p < act_duty_q) ? '1 : '0;
            3'b010:  sample = p[DATA_W-1] ? ~tri_up : tri_up;
            3'b011:  sample = ~p;
            3'b110:  sample = bus.romIn;
            default: sample = '0;
        endcase
    end

    always_comb begin
        sum     = {1'b0, phase_q} + {1'b0, act_freq_q};
        carry   = sum[PHASE_W];
        phase_d = sum[PHASE_W-1:0];
        wrap_d  = carry;

        act_freq_d  = act_freq_q;
        act_duty_d  = act_duty_q;
        act_sel_d   = act_sel_q;
        pend_freq_d = pend_freq_q;
        pend_duty_d = pend_duty_q;
        pend_sel_d  = pend_sel_q;
        state_d     = state_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cfgLoad) begin
                    pend_freq_d = bus.freqWord;
                    pend_duty_d = bus.duty;
                    pend_sel_d  = bus.waveSelector;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                // A stopped accumulator never wraps, so apply straight away.
                if (carry || (act_freq_q == '0)) begin
                    act_freq_d = pend_freq_q;
                    act_duty_d = pend_duty_q;
                    act_sel_d  = pend_sel_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef WAVEGEN_AMP_EN
        stage_d     = sample;
        stage_vld_d = 1'b1;
        // amplitude+1 makes all-ones unity gain; amplitude is sampled live.
        amp_p1      = {1'b0, bus.amplitude} + {{DATA_W{1'b0}}, 1'b1};
        product     = {{(DATA_W+1){1'b0}}, stage_q} * {{DATA_W{1'b0}}, amp_p1};
        data_d      = DATA_W'(product >> DATA_W);
        valid_d     = stage_vld_q;
`else
        data_d      = sample;
        valid_d     = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q     <= '0;
            act_freq_q  <= '0;
            act_duty_q  <= DUTY_RST;
            act_sel_q   <= '0;
            pend_freq_q <= '0;
            pend_duty_q <= '0;
            pend_sel_q  <= '0;
            state_q     <= ST_IDLE;
            data_q      <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef WAVEGEN_AMP_EN
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
`endif
        end else begin
            phase_q     <= phase_d;
            act_freq_q  <= act_freq_d;
            act_duty_q  <= act_duty_d;
            act_sel_q   <= act_sel_d;
            pend_freq_q <= pend_freq_d;
            pend_duty_q <= pend_duty_d;
            pend_sel_q  <= pend_sel_d;
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
`ifdef WAVEGEN_AMP_EN
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
`endif
        end
    end

    assign bus.cfgBusy   = (state_q == ST_PEND);
    assign bus.romAddr   = phase_q[PHASE_W-1 -: ROM_AW];
    assign bus.dataOut   = data_q;
    assign bus.dataValid = valid_q;
    assign bus.wrapPulse = wrap_q;

endmodule

// File: tb/tb_wavegen_nco.sv
module tb_wavegen_nco;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 16;
    localparam int unsigned AW = 8;
`ifdef WAVEGEN_AMP_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    wavegen_nco_if #(.DATA_W(DW), .PHASE_W(PW), .ROM_AW(AW)) bus ();

    wavegen_nco #(.DATA_W(DW), .PHASE_W(PW), .ROM_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] rom_mem [0:255];
    assign bus.romIn = rom_mem[bus.romAddr];

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       busy;
        logic       wrap;
        logic [7:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned popped = 0;

    // Reference sample from phase and configuration, plain arithmetic.
    function automatic int unsigned ref_sample(int unsigned ph, int unsigned sel,
                                               int unsigned dty);
        int unsigned pv;
        pv = ph / 256;
        case (sel)
            0:       return pv;
            1:       return (pv < dty) ? 255 : 0;
            2:       return (pv < 128) ? 2 * pv : 255 - 2 * (pv - 128);
            3:       return 255 - pv;
            6:       return int'(rom_mem[pv]);
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic load(input int unsigned f, input int unsigned d, input int unsigned s);
        @(negedge clk);
        bus.freqWord     = 16'(f);
        bus.duty         = 8'(d);
        bus.waveSelector = 3'(s);
        bus.cfgLoad      = 1'b1;
        @(negedge clk);
        bus.cfgLoad      = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.cfgBusy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom_range(0, 255));
        bus.freqWord     = '0;
        bus.duty         = '0;
        bus.waveSelector = '0;
        bus.cfgLoad      = 1'b0;
`ifdef WAVEGEN_AMP_EN
        bus.amplitude    = 8'hFF;
`endif
        fork
            // Reference model: cycle-level behaviour derived from the rules.
            begin : model
                int unsigned m_phase, m_freq, m_duty, m_sel;
                int unsigned p_freq, p_duty, p_sel, smp, nxt;
                int unsigned s1;
                bit m_busy, carry, s1v;
                exp_t e;
                m_phase = 0; m_freq = 0; m_duty = 128; m_sel = 0;
                p_freq = 0; p_duty = 0; p_sel = 0; m_busy = 0; s1 = 0; s1v = 0;
                forever begin
                    @(posedge clk);
                    if (!rst) begin
                        m_phase = 0; m_freq = 0; m_duty = 128; m_sel = 0;
                        p_freq = 0; p_duty = 0; p_sel = 0; m_busy = 0;
                        s1 = 0; s1v = 0;
                        sb_q.delete();
                    end else begin
                        smp   = ref_sample(m_phase, m_sel, m_duty);
                        nxt   = m_phase + m_freq;
                        carry = (nxt >= 65536);
                        nxt   = nxt % 65536;
                        if (m_busy) begin
                            if (carry || m_freq == 0) begin
                                m_freq = p_freq; m_duty = p_duty; m_sel = p_sel;
                                m_busy = 0;
                            end
                        end else if (bus.cfgLoad) begin
                            p_freq = bus.freqWord; p_duty = bus.duty;
                            p_sel  = bus.waveSelector;
                            m_busy = 1;
                        end
                        m_phase = nxt;
                        e.busy = m_busy;
                        e.wrap = carry;
                        e.addr = 8'(m_phase / 256);
`ifdef WAVEGEN_AMP_EN
                        if (s1v) begin
                            e.data = 8'((s1 * (int'(bus.amplitude) + 1)) / 256);
                            sb_q.push_back(e);
                        end
                        s1  = smp;
                        s1v = 1;
`else
                        e.data = 8'(smp);
                        sb_q.push_back(e);
`endif
                    end
                end
            end
            // Monitor: compares every presented sample against the scoreboard.
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (bus.dataValid) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_empty: dataValid high with no expected sample");
                        end else begin
                            e = sb_q.pop_front();
                            popped++;
                            if (bus.dataOut !== e.data || bus.cfgBusy !== e.busy ||
                                bus.wrapPulse !== e.wrap || bus.romAddr !== e.addr) begin
                                errors++;
                                $display("FAIL sample @%0t: got data=%0h busy=%0b wrap=%0b addr=%0h, expected data=%0h busy=%0b wrap=%0b addr=%0h",
                                         $time, bus.dataOut, bus.cfgBusy, bus.wrapPulse, bus.romAddr,
                                         e.data, e.busy, e.wrap, e.addr);
                            end
                        end
                    end
                end
            end
            begin : stimulus
                int busy_cnt, cnt_a, cnt_b, n;
                logic [7:0] prev;

                repeat (3) @(negedge clk);
                chk("rst0_valid", bus.dataValid, 0);
                chk("rst0_busy", bus.cfgBusy, 0);
                rst = 1'b1;

                // Sawtooth right after reset: busy for exactly one cycle.
                load(32'h0100, 32'h80, 0);
                busy_cnt = 0;
                for (int i = 0; i < 10; i++) begin
                    if (bus.cfgBusy) busy_cnt++;
                    @(negedge clk);
                end
                chk("saw_busy_cycles", busy_cnt, 1);
                cnt_a = 0; cnt_b = 0;
                prev = bus.dataOut;
                for (int i = 0; i < 512; i++) begin
                    @(negedge clk);
                    if (bus.wrapPulse) cnt_a++;
                    if (bus.dataOut != 8'(prev + 8'd1)) cnt_b++;
                    prev = bus.dataOut;
                end
                chk("saw_wraps_512", cnt_a, 2);
                chk("saw_slope_errs", cnt_b, 0);

                // Square with duty 0x40, then duty 0.
                load(32'h0100, 32'h40, 1);
                wait_idle("sq");
                repeat (LAT) @(negedge clk);
                cnt_a = 0; cnt_b = 0;
                for (int i = 0; i < 256; i++) begin
                    @(negedge clk);
                    if (bus.dataOut == 8'hFF) cnt_a++;
                    if (bus.dataOut == 8'h00) cnt_b++;
                end
                chk("sq_high", cnt_a, 64);
                chk("sq_low", cnt_b, 192);
                load(32'h0100, 32'h00, 1);
                wait_idle("sq0");
                repeat (LAT) @(negedge clk);
                cnt_a = 0;
                for (int i = 0; i < 256; i++) begin
                    @(negedge clk);
                    if (bus.dataOut != 8'h00) cnt_a++;
                end
                chk("sq_duty0_nonzero", cnt_a, 0);

                // Triangle, period 128.
                load(32'h0200, 32'h00, 2);
                wait_idle("tri");
                repeat (LAT) @(negedge clk);
                cnt_a = 0; cnt_b = 0;
                for (int i = 0; i < 256; i++) begin
                    @(negedge clk);
                    if (bus.dataOut == 8'h00) cnt_a++;
                    if (bus.dataOut == 8'hFF) cnt_b++;
                end
                chk("tri_zeros", cnt_a, 2);
                chk("tri_peaks", cnt_b, 2);

                // Glitch-free frequency change from phase 0x4000.
                load(32'h0100, 32'h80, 0);
                wait_idle("glf0");
                n = 0;
                while (bus.romAddr != 8'h3F && n < 600) begin
                    @(negedge clk);
                    n++;
                end
                chk("glf_find_phase", bus.romAddr, 8'h3F);
                bus.freqWord = 16'h0400;
                bus.cfgLoad  = 1'b1;
                @(negedge clk);
                bus.cfgLoad  = 1'b0;
                busy_cnt = 0;
                n = 0;
                while (bus.cfgBusy && n < 1000) begin
                    busy_cnt++;
                    n++;
                    if (busy_cnt == 50) begin
                        bus.freqWord = 16'h0800;
                        bus.cfgLoad  = 1'b1;
                    end else begin
                        bus.cfgLoad  = 1'b0;
                    end
                    @(negedge clk);
                end
                bus.cfgLoad = 1'b0;
                chk("glf_busy_cycles", busy_cnt, 192);
                chk("glf_wrap_at_fall", bus.wrapPulse, 1);
                chk("glf_addr_at_fall", bus.romAddr, 0);
                @(negedge clk);
                chk("glf_new_slope", bus.romAddr, 4);

                // ROM playback.
                load(32'h0100, 32'h00, 6);
                wait_idle("rom");
                repeat (300) @(negedge clk);

`ifdef WAVEGEN_AMP_EN
                bus.amplitude = 8'h7F;
                load(32'h0100, 32'h00, 0);
                wait_idle("amp");
                repeat (300) @(negedge clk);
`endif

                // Reset while a configuration is pending.
                load(32'h1234, 32'h10, 3);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                chk("rst_dataOut", bus.dataOut, 0);
                chk("rst_dataValid", bus.dataValid, 0);
                chk("rst_cfgBusy", bus.cfgBusy, 0);
                chk("rst_wrapPulse", bus.wrapPulse, 0);
                chk("rst_romAddr", bus.romAddr, 0);
                rst = 1'b1;
                repeat (5) @(negedge clk);
                chk("rst_pend_discard_addr", bus.romAddr, 0);
                chk("rst_pend_discard_busy", bus.cfgBusy, 0);

                // Randomised configuration traffic.
                for (int i = 0; i < 4000; i++) begin
                    @(negedge clk);
`ifdef WAVEGEN_AMP_EN
                    bus.amplitude = 8'($urandom_range(0, 255));
`endif
                    if ($urandom_range(0, 15) == 0) begin
                        bus.freqWord     = 16'($urandom_range(0, 65535) >> $urandom_range(0, 8));
                        bus.duty         = 8'($urandom_range(0, 255));
                        bus.waveSelector = 3'($urandom_range(0, 7));
                        bus.cfgLoad      = 1'b1;
                    end else begin
                        bus.cfgLoad      = 1'b0;
                    end
                end
                bus.cfgLoad = 1'b0;
                repeat (4) @(negedge clk);
                #1;
                chk("sb_drained", sb_q.size(), 0);
                chk("sb_enough_samples", (popped > 5000) ? 1 : 0, 1);

                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join_any
    end
endmodule
